relu_stream_sched: RTL and testbench
====================================

Name: relu_stream_sched

Overview:
- Sequencer for the FP16 ReLU stage between the conv layer's output feature-map buffer (e.g. C3, 16ch x 10x10) and the next layer.
- Walks the input buffer in address order, one word per cycle, over a synchronous read port with 1-cycle read latency.
- Applies FP16 ReLU and emits results on a valid/ready stream tagged with address and channel.
- Provides start/busy/done control so the layer scheduler can chain it after the conv engine.

Parameters:
- DATA_WIDTH, 16, element width (IEEE FP16; bit 15 = sign).
- H, 10, feature-map height.
- W, 10, feature-map width.
- CHANNELS, 16, number of channels; N = H*W*CHANNELS elements per frame.
- AW, 16, address width; N <= 2**AW is required (assertion in simulation).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a frame; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last output handshake.
- rd_en  out  1  read request to input buffer.
- rd_addr  out  AW  read address, 0..N-1 ascending.
- rd_data  in  DATA_WIDTH  valid exactly 1 cycle after rd_en.
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  ReLU result.
- out_addr  out  AW  element index of out_data (same layout as input).
- out_chan  out  5  channel index = out_addr / (H*W).
- chan_last  out  1  high with out_valid on the last element of a channel.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, rd_en, out_valid, chan_last = 0; rd_addr, out_addr, out_chan, out_data = 0; FIFO and counters cleared.
- Reset mid-frame aborts the frame immediately: no done pulse, and in-flight reads are discarded.
- Element transform: out = (in[15] == 1) ? 16'h0000 : in. This covers -0, negative numbers, -inf and negative NaN.
- FSM:
  - IDLE: on start, go to RUN; rd_addr = 0.
  - RUN: issue reads; when rd_cnt == N, go to DRAIN.
  - DRAIN: on the last handshake (out_cnt == N-1 and out_valid and out_ready), go to DONE.
  - DONE: 1 cycle; done = 1, busy = 0; then go to IDLE.
- start while busy is ignored. start in the DONE cycle is ignored. start in IDLE restarts the frame from address 0.
- Buffering:
  - 2-entry output FIFO, plus an inflight flag for a read issued in the previous cycle.
  - rd_en = RUN and rd_cnt < N and (fifo_cnt + inflight - pop) < 2, where pop = out_valid and out_ready in that cycle.
  - The FIFO never overflows; an overflow is a simulation assertion failure.
- Throughput and latency:
  - With out_ready held high: one element per cycle.
  - First rd_en in the cycle after start is accepted.
  - First out_valid two cycles after start.
  - done at start + N + 2 cycles.
- Backpressure:
  - While out_valid and !out_ready, out_data, out_addr, out_chan and chan_last hold stable.
  - Reads stall within one cycle.
  - No element is lost or duplicated.
- rd_addr increments only on rd_en and stops at N-1. It is never driven past N-1.
- out_addr increments on each handshake. out_chan increments when chan_last handshakes.
- chan_last = (out_addr % (H*W) == H*W-1). This is computed with a per-channel counter, not a divider.
- Arithmetic: counters are AW+1 bits wide to hold N without wrap. No other arithmetic is performed.

Optional Feature:
- Macro: RELU_NAN_FLUSH_EN.
- When defined: any input with exponent 5'h1F and mantissa != 0 (positive or negative NaN) outputs 16'h0000. A sticky status output nan_seen (1 bit) is added; it clears on an accepted start and on reset.
- When undefined: the sign-bit rule only. Positive NaN (e.g. 16'h7E00) passes unchanged, and there is no nan_seen port.
- Infinities follow the sign rule in both modes.

Test Plan:
- Buffer preloaded with 1600 words alternating 16'h3C00 / 16'hBC00, out_ready = 1, pulse start -> outputs 3C00,0000,... at out_addr 0..1599; done exactly at start + 1602 cycles; busy high for 1601 cycles.
- Special values 16'h8000, 16'hFC00, 16'h7C00, 16'h0001, 16'h7E00 -> 0000, 0000, 7C00, 0001, 7E00; the last one gives 0000 and nan_seen = 1 when RELU_NAN_FLUSH_EN is defined.
- Random out_ready at 30% duty -> output sequence matches the reference model in order with no gaps or duplicates; FIFO never overflows; data is held stable while stalled.
- chan_last checks -> chan_last asserts at out_addr 99, 199, ..., 1599 (16 pulses); out_chan steps 0 to 15.
- rst_n asserted at element 700, then a new start -> no done from the aborted frame; the new frame starts at rd_addr 0 and completes all 1600 elements.
- start pulsed while busy and during the DONE cycle -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/relu_stream_sched.sv
// relu_stream_sched: walks an FP16 feature-map buffer in address order, applies
// ReLU and streams the results on a valid/ready port tagged with element index
// and channel. A 2-entry output FIFO plus one in-flight read absorbs the
// 1-cycle read latency so the stream runs at one element per cycle when
// downstream never stalls.
// Optional feature: define RELU_NAN_FLUSH_EN to flush every NaN to zero and to
// add the sticky nan_seen status output.
module relu_stream_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int H          = 10,
    parameter int W          = 10,
    parameter int CHANNELS   = 16,
    parameter int AW         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [AW-1:0]         out_addr,
    output logic [4:0]            out_chan,
    output logic                  chan_last
`ifdef RELU_NAN_FLUSH_EN
    ,
    output logic                  nan_seen
`endif
);

    localparam int              PLANE      = H * W;
    localparam int              N          = PLANE * CHANNELS;
    localparam logic [AW:0]     N_C        = (AW+1)'(N);
    localparam logic [AW:0]     N_LAST     = (AW+1)'(N - 1);
    localparam logic [AW-1:0]   ADDR_LAST  = AW'(N - 1);
    localparam logic [AW-1:0]   PLANE_LAST = AW'(PLANE - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [AW:0]             rd_cnt;
    logic [AW:0]             out_cnt;
    logic [AW-1:0]           chan_pos;
    logic                    inflight;
    logic [DATA_WIDTH-1:0]   fifo_mem [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              fifo_cnt;
    logic                    start_ok, pop, fifo_push, fifo_pop, last_hs;
    logic [2:0]              occ_next;

    function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] x);
`ifdef RELU_NAN_FLUSH_EN
        if (x[DATA_WIDTH-1] || is_nan(x)) return '0;
`else
        if (x[DATA_WIDTH-1]) return '0;
`endif
        return x;
    endfunction

    // The FIFO head takes priority; otherwise the word arriving this cycle is
    // forwarded directly so the first result appears one cycle after its read.
    assign out_valid = (fifo_cnt != 2'd0) || inflight;
    assign out_data  = (fifo_cnt != 2'd0) ? fifo_mem[rd_ptr] :
                       inflight           ? relu(rd_data)     : '0;
    assign out_addr  = out_cnt[AW-1:0];
    assign chan_last = out_valid && (chan_pos == PLANE_LAST);

    assign start_ok  = (state == S_IDLE) && start;
    assign pop       = out_valid && out_ready;
    assign fifo_push = inflight && !(pop && (fifo_cnt == 2'd0));
    assign fifo_pop  = pop && (fifo_cnt != 2'd0);
    assign last_hs   = pop && (out_cnt == N_LAST);

    // Occupancy next cycle, counting the forwarded word as consumed when popped.
    assign occ_next  = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign rd_en     = (state == S_RUN) && (rd_cnt < N_C) && (occ_next < 3'd2);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and control outputs.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can
        // leave a signal unassigned and infer a latch.
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (last_hs)             state_nxt = S_DONE;
                else if (rd_cnt == N_C)  state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (last_hs) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read address generation; the address saturates at the final element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt   <= '0;
            rd_addr  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (start_ok) begin
                rd_cnt  <= '0;
                rd_addr <= '0;
            end else if (rd_en) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_addr != ADDR_LAST) rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    // FIFO occupancy and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (fifo_push) wr_ptr <= ~wr_ptr;
            if (fifo_pop)  rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    // FIFO storage holds already-transformed results.
    // NOTE: storage has no reset; fifo_cnt gates every read of it, so stale
    // contents are never observable.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= relu(rd_data);
    end

    // Output element index and channel position advance on each handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt  <= '0;
            chan_pos <= '0;
            out_chan <= '0;
        end else if (start_ok) begin
            out_cnt  <= '0;
            chan_pos <= '0;
            out_chan <= '0;
        end else if (pop) begin
            out_cnt <= out_cnt + 1'b1;
            if (chan_last) begin
                chan_pos <= '0;
                out_chan <= out_chan + 5'd1;
            end else begin
                chan_pos <= chan_pos + 1'b1;
            end
        end
    end

`ifdef RELU_NAN_FLUSH_EN
    // Sticky NaN flag, cleared when a new frame is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        nan_seen <= 1'b0;
        else if (start_ok)                 nan_seen <= 1'b0;
        else if (inflight && is_nan(rd_data)) nan_seen <= 1'b1;
    end
`endif

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && !fifo_pop && (fifo_cnt == 2'd2)));

    frame_fits_addr: assert property (@(posedge clk) disable iff (!rst_n)
        (64'(N) <= (64'd1 << AW)));

endmodule

// File: tb/tb_relu_stream_sched.sv
// Self-checking bench for relu_stream_sched: a negedge compare process checks
// every valid output beat against a reference model built from the element
// index (data = ReLU of the preloaded buffer word, channel = index / plane),
// plus directed frames with hand-computed timing and data literals.
module tb_relu_stream_sched;

    localparam int N      = 1600;
    localparam int PLANE  = 100;
    localparam int BUDGET = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b1;
    logic        busy, done, rd_en, out_valid, chan_last;
    logic [15:0] rd_addr, out_addr, out_data;
    logic [15:0] rd_data = 16'h0000;
    logic [4:0]  out_chan;
`ifdef RELU_NAN_FLUSH_EN
    logic        nan_seen;
`endif

    logic [15:0] mem [N];
    logic [15:0] got [N];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // compare-process state, read by the directed tests
    int idx = 0, rd_idx = 0, cl_cnt = 0, frame_cl = 0, done_cnt = 0;
    bit stalled = 1'b0;
    logic [37:0] prev_beat;

    relu_stream_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_chan  (out_chan),
        .chan_last (chan_last)
`ifdef RELU_NAN_FLUSH_EN
        ,
        .nan_seen  (nan_seen)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Input buffer with one cycle of read latency.
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference ReLU: negative values become zero (NaNs too when flushing).
    function automatic logic [15:0] ref_relu(input logic [15:0] x);
`ifdef RELU_NAN_FLUSH_EN
        if (x[14:10] == 5'h1F && x[9:0] != 10'h000) return 16'h0000;
`endif
        return x[15] ? 16'h0000 : x;
    endfunction

    // Compare process: read address order, every output beat, hold-while-stalled,
    // and per-frame totals at done.
    always @(negedge clk) begin
        logic [37:0] cur, exp_beat;
        if (!rst_n) begin
            idx = 0; rd_idx = 0; cl_cnt = 0; stalled = 1'b0;
        end else begin
            if (rd_en) begin
                check("rd_addr_order", 64'(rd_addr), 64'(rd_idx));
                rd_idx++;
            end
            if (out_valid) begin
                cur = {out_data, out_addr, out_chan, chan_last};
                if (stalled) check("hold_while_stalled", 64'(cur), 64'(prev_beat));
                check("out_idx_in_range", 64'(idx < N), 64'd1);
                if (idx < N) begin
                    exp_beat = {ref_relu(mem[idx]), 16'(idx), 5'(idx / PLANE),
                                1'(idx % PLANE == PLANE - 1)};
                    check("out_beat", 64'(cur), 64'(exp_beat));
                    got[idx] = out_data;
                end
                if (out_ready) begin
                    if (chan_last) cl_cnt++;
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    prev_beat = cur;
                end
            end else if (stalled) begin
                check("valid_held_while_stalled", 64'(out_valid), 64'd1);
                stalled = 1'b0;
            end
            if (done) begin
                check("frame_out_count", 64'(idx), 64'(N));
                check("frame_read_count", 64'(rd_idx), 64'(N));
                done_cnt++;
                frame_cl = cl_cnt;
                cl_cnt = 0; idx = 0; rd_idx = 0;
            end
        end
    end

    // Start one frame and wait for done. lat = cycles from start to done,
    // bcyc = cycles with busy high. extra pulses start mid-frame and in DONE.
    task automatic run_frame(input bit rnd, input bit extra, output int lat, output int bcyc);
        int t0;
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc; lat = -1; bcyc = 0;
        for (int k = 0; k < BUDGET; k++) begin
            @(posedge clk); #1;
            start     = extra && (k == 500);
            out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (busy) bcyc++;
            if (done) begin
                lat = cyc - t0;
                if (extra) start = 1'b1;
                break;
            end
        end
        check("frame_done_seen", 64'(done), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        int lat, bcyc, d0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_done",      64'(done),      64'd0);
        check("rst_rd_en",     64'(rd_en),     64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_chan_last", 64'(chan_last), 64'd0);
        check("rst_addrs",     64'({rd_addr, out_addr, out_chan, out_data}), 64'd0);
        rst_n = 1'b1;

        // Alternating +1.0 / -1.0, full throughput
        for (int i = 0; i < N; i++) mem[i] = (i % 2 == 0) ? 16'h3C00 : 16'hBC00;
        run_frame(1'b0, 1'b0, lat, bcyc);
        check("t1_latency",  64'(lat),  64'd1602);
        check("t1_busy_cyc", 64'(bcyc), 64'd1601);
        check("t1_out0",     64'(got[0]),    64'h3C00);
        check("t1_out1",     64'(got[1]),    64'h0000);
        check("t1_out1598",  64'(got[1598]), 64'h3C00);
        check("t1_out1599",  64'(got[1599]), 64'h0000);
        check("t1_chan_last_pulses", 64'(frame_cl), 64'd16);
        check("t1_final_chan", 64'(out_chan), 64'd16);
`ifdef RELU_NAN_FLUSH_EN
        check("t1_nan_seen", 64'(nan_seen), 64'd0);
`endif

        // Special values
        for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h8000; mem[1] = 16'hFC00; mem[2] = 16'h7C00;
        mem[3] = 16'h0001; mem[4] = 16'h7E00;
        run_frame(1'b0, 1'b0, lat, bcyc);
        check("sp_neg_zero", 64'(got[0]), 64'h0000);
        check("sp_neg_inf",  64'(got[1]), 64'h0000);
        check("sp_pos_inf",  64'(got[2]), 64'h7C00);
        check("sp_denorm",   64'(got[3]), 64'h0001);
`ifdef RELU_NAN_FLUSH_EN
        check("sp_pos_nan",  64'(got[4]), 64'h0000);
        check("sp_nan_seen", 64'(nan_seen), 64'd1);
`else
        check("sp_pos_nan",  64'(got[4]), 64'h7E00);
`endif

        // Random backpressure at 30% ready
        for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
        d0 = done_cnt;
        run_frame(1'b1, 1'b0, lat, bcyc);
        check("bp_chan_last_pulses", 64'(frame_cl), 64'd16);
        check("bp_one_done", 64'(done_cnt - d0), 64'd1);
        out_ready = 1'b1;

        // Reset at element 700, then a complete new frame
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < BUDGET; k++) begin
            if (idx >= 700) break;
            @(posedge clk); #1;
        end
        check("abort_reached_700", 64'(idx >= 700), 64'd1);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",      64'(busy),      64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_rd",        64'({rd_en, rd_addr}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_frame(1'b0, 1'b0, lat, bcyc);
        check("restart_latency", 64'(lat), 64'd1602);
        check("restart_one_done", 64'(done_cnt - d0), 64'd1);

        // start while busy and during DONE is ignored
        d0 = done_cnt;
        run_frame(1'b0, 1'b1, lat, bcyc);
        check("ign_latency", 64'(lat), 64'd1602);
        repeat (3) @(posedge clk);
        #1;
        check("ign_no_restart", 64'(busy), 64'd0);
        check("ign_one_done",   64'(done_cnt - d0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
